// File: rtl/instr_type_pkg.sv
// Shared types for the SYSTEM execute slice: instruction kinds, CSR addresses,
// trap causes and the execute FSM states.
package instr_type_pkg;

   typedef enum logic [3:0] {
      SYSK_INVALID = 4'd0,
      SYSK_ECALL   = 4'd1,
      SYSK_EBREAK  = 4'd2,
      SYSK_CSRRW   = 4'd3,
      SYSK_CSRRS   = 4'd4,
      SYSK_CSRRC   = 4'd5,
      SYSK_CSRRWI  = 4'd6,
      SYSK_CSRRSI  = 4'd7,
      SYSK_CSRRCI  = 4'd8
   } system_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } exec_state_t;

   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mtvec/mscratch/mepc/mcause, free-running 64-bit
// mcycle, combinational read mux with address-valid flag and one write port.
module csr_regfile
   import instr_type_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     addr,
   output logic [XLEN-1:0] rd_data,
   output logic            addr_ok,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   output logic [XLEN-1:0] mtvec
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [XLEN-1:0] mtvec_r;
   logic [XLEN-1:0] mscratch_r;
   logic [XLEN-1:0] mepc_r;
   logic [XLEN-1:0] mcause_r;
   logic [63:0]     mcycle_r;
   logic [63:0]     cycle_inc;
   logic [63:0]     cycle_d;

   // Low alignment bits are stored but always read back as zero.
   assign mtvec     = mtvec_r & ALIGN_MASK;
   assign cycle_inc = mcycle_r + 64'd1;

   // Read mux and address decode.
   always_comb begin
      rd_data = '0;
      addr_ok = 1'b1;
      case (addr)
         CSR_MTVEC:    rd_data = mtvec_r & ALIGN_MASK;
         CSR_MSCRATCH: rd_data = mscratch_r;
         CSR_MEPC:     rd_data = mepc_r & ALIGN_MASK;
         CSR_MCAUSE:   rd_data = mcause_r;
         CSR_MCYCLE:   rd_data = mcycle_r[31:0];
         CSR_MCYCLEH:  rd_data = mcycle_r[63:32];
         default:      addr_ok = 1'b0;
      endcase
   end

   // A write to one counter half overrides it; the other half keeps the carry.
   always_comb begin
      if (wr_en && (addr == CSR_MCYCLE)) begin
         cycle_d = {cycle_inc[63:32], wr_data};
      end else if (wr_en && (addr == CSR_MCYCLEH)) begin
         cycle_d = {wr_data, cycle_inc[31:0]};
      end else begin
         cycle_d = cycle_inc;
      end
   end

   // CSR storage, trap capture and cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtvec_r    <= MTVEC_RESET;
         mscratch_r <= '0;
         mepc_r     <= '0;
         mcause_r   <= '0;
         mcycle_r   <= 64'd0;
      end else begin
         mcycle_r <= cycle_d;
         if (trap_en) begin
            mepc_r   <= trap_pc;
            mcause_r <= trap_cause;
         end else if (wr_en) begin
            case (addr)
               CSR_MTVEC:    mtvec_r    <= wr_data;
               CSR_MSCRATCH: mscratch_r <= wr_data;
               CSR_MEPC:     mepc_r     <= wr_data;
               CSR_MCAUSE:   mcause_r   <= wr_data;
               default:      mtvec_r    <= mtvec_r;
            endcase
         end
      end
   end

endmodule

// File: rtl/system_exec.sv
// Execute-stage unit for decoded RV32I SYSTEM instructions: CSR read-modify-write
// and ecall/ebreak/illegal-access traps behind valid/ready request and response.
module system_exec
   import instr_type_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  system_kind_t    kind,
   input  logic [11:0]     csr_addr,
   input  logic [4:0]      rd,
   input  logic [4:0]      rs1,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] pc,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            rd_we,
   output logic [XLEN-1:0] rd_data,
   output logic            trap,
   output logic [XLEN-1:0] trap_target
);

   exec_state_t     state;
   system_kind_t    kind_r;
   logic [11:0]     addr_r;
   logic [4:0]      rd_r;
   logic [4:0]      rs1_r;
   logic [XLEN-1:0] rs1_val_r;
   logic [XLEN-1:0] pc_r;

   logic [XLEN-1:0] old_val;
   logic [XLEN-1:0] new_val;
   logic [XLEN-1:0] zimm;
   logic [XLEN-1:0] cause;
   logic [XLEN-1:0] mtvec;
   logic            addr_ok;
   logic            is_csr;
   logic            wr_req;
   logic            trap_now;
   logic            csr_wr;
   logic            trap_en;

   assign zimm     = {{(XLEN-5){1'b0}}, rs1_r};
   assign trap_now = !is_csr || !addr_ok;
   assign csr_wr   = (state == ST_EXEC) && !trap_now && wr_req;
   assign trap_en  = (state == ST_EXEC) && trap_now;

   csr_regfile #(
      .XLEN        (XLEN),
      .MTVEC_RESET (MTVEC_RESET)
   ) u_csr (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr_r),
      .rd_data    (old_val),
      .addr_ok    (addr_ok),
      .wr_en      (csr_wr),
      .wr_data    (new_val),
      .trap_en    (trap_en),
      .trap_pc    (pc_r),
      .trap_cause (cause),
      .mtvec      (mtvec)
   );

   // Read-modify-write value; set/clear with a zero source are read-only.
   always_comb begin
      is_csr  = 1'b1;
      wr_req  = 1'b1;
      new_val = old_val;
      case (kind_r)
         SYSK_CSRRW:  new_val = rs1_val_r;
         SYSK_CSRRS:  begin new_val = old_val | rs1_val_r;  wr_req = (rs1_r != 5'd0); end
         SYSK_CSRRC:  begin new_val = old_val & ~rs1_val_r; wr_req = (rs1_r != 5'd0); end
         SYSK_CSRRWI: new_val = zimm;
         SYSK_CSRRSI: begin new_val = old_val | zimm;       wr_req = (rs1_r != 5'd0); end
         SYSK_CSRRCI: begin new_val = old_val & ~zimm;      wr_req = (rs1_r != 5'd0); end
         default:     begin is_csr = 1'b0;                  wr_req = 1'b0; end
      endcase
   end

   // Trap cause selection.
   always_comb begin
      if (kind_r == SYSK_ECALL) begin
         cause = CAUSE_ECALL;
      end else if (kind_r == SYSK_EBREAK) begin
         cause = CAUSE_EBREAK;
      end else begin
         cause = CAUSE_ILLEGAL;
      end
   end

   // IDLE -> EXEC -> RESP handshake FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         rd_we       <= 1'b0;
         rd_data     <= '0;
         trap        <= 1'b0;
         trap_target <= '0;
         kind_r      <= SYSK_INVALID;
         addr_r      <= 12'd0;
         rd_r        <= 5'd0;
         rs1_r       <= 5'd0;
         rs1_val_r   <= '0;
         pc_r        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  kind_r    <= kind;
                  addr_r    <= csr_addr;
                  rd_r      <= rd;
                  rs1_r     <= rs1;
                  rs1_val_r <= rs1_val;
                  pc_r      <= pc;
                  req_ready <= 1'b0;
                  state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_valid  <= 1'b1;
               trap        <= trap_now;
               trap_target <= trap_now ? mtvec : '0;
               rd_we       <= !trap_now && (rd_r != 5'd0);
               rd_data     <= trap_now ? '0 : old_val;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  rd_we      <= 1'b0;
                  trap       <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_system_exec.sv
// Directed scoreboard bench for system_exec: expected responses are queued at
// request time and compared when the response handshake completes.
module tb_system_exec;
   import instr_type_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] data;
      logic        trp;
      logic [31:0] target;
      logic        chk_data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   system_kind_t kind;
   logic [11:0]  csr_addr;
   logic [4:0]   rd;
   logic [4:0]   rs1;
   logic [31:0]  rs1_val;
   logic [31:0]  pc;
   logic         resp_valid;
   logic         resp_ready;
   logic         rd_we;
   logic [31:0]  rd_data;
   logic         trap;
   logic [31:0]  trap_target;

   int   checks = 0;
   int   fails  = 0;
   exp_t sb_q[$];
   logic [31:0] last_data;

   always #5 clk = ~clk;

   system_exec dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .kind(kind), .csr_addr(csr_addr), .rd(rd), .rs1(rs1), .rs1_val(rs1_val), .pc(pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .rd_we(rd_we), .rd_data(rd_data),
      .trap(trap), .trap_target(trap_target)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // One transaction: queue expectation, drive, check latency, compare, release.
   task automatic xact(input string tag, input system_kind_t k, input logic [11:0] a,
                       input logic [4:0] rdi, input logic [4:0] rs1i, input logic [31:0] v,
                       input logic [31:0] p, input logic ewe, input logic [31:0] edata,
                       input logic etrp, input logic [31:0] etgt, input logic chk_d,
                       input int hold);
      exp_t e;
      int   waited;
      logic seen;
      logic [31:0] s_data, s_tgt;
      logic s_we, s_trp;
      sb_q.push_back('{we: ewe, data: edata, trp: etrp, target: etgt, chk_data: chk_d});
      check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; kind = k; csr_addr = a; rd = rdi; rs1 = rs1i; rs1_val = v; pc = p;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0; kind = SYSK_ECALL; csr_addr = 12'h7FF; rd = 5'd31;
      rs1 = 5'd31; rs1_val = $urandom; pc = $urandom;
      @(negedge clk);
      check({tag, ".exec_no_resp"}, {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      seen = resp_valid;
      check({tag, ".latency"}, {31'd0, resp_valid}, 32'd1);
      waited = 0;
      while (!seen && waited < 8) begin
         @(negedge clk);
         seen = resp_valid;
         waited++;
      end
      e = sb_q.pop_front();
      if (!seen) begin
         check({tag, ".timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, e.we});
         check({tag, ".trap"}, {31'd0, trap}, {31'd0, e.trp});
         check({tag, ".trap_target"}, trap_target, e.target);
         if (e.chk_data) check({tag, ".rd_data"}, rd_data, e.data);
         last_data = rd_data;
         s_data = rd_data; s_tgt = trap_target; s_we = rd_we; s_trp = trap;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
            check({tag, ".hold_data"}, {rd_data[31:2], rd_we, trap} ^ {s_data[31:2], s_we, s_trp},
                  32'd0);
            check({tag, ".hold_lo"}, {rd_data[1:0], trap_target[31:2]}, {s_data[1:0], s_tgt[31:2]});
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         @(negedge clk);
         check({tag, ".back_idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
      end
   endtask

   task automatic rd_csr(input string tag, input logic [11:0] a, input logic [31:0] expv);
      xact(tag, SYSK_CSRRS, a, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, expv, 1'b0, 32'd0, 1'b1, 0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; kind = SYSK_INVALID; csr_addr = 12'd0; rd = 5'd0;
      rs1 = 5'd0; rs1_val = 32'd0; pc = 32'd0; resp_ready = 1'b0; last_data = 32'd0;
      repeat (3) @(negedge clk);
      check("reset.outs", {26'd0, req_ready, resp_valid, rd_we, trap, 2'b00}, 32'h20);
      check("reset.rd_data", rd_data, 32'd0);
      check("reset.trap_target", trap_target, 32'd0);
      rst = 1'b0;

      // 1. reset values
      xact("mcycle0", SYSK_CSRRS, CSR_MCYCLE, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0,
           32'd0, 1'b0, 0);
      check("mcycle0.small", {31'd0, last_data < 32'd32}, 32'd1);
      rd_csr("mtvec0", CSR_MTVEC, 32'h0000_0100);

      // 2. csrrw swap
      xact("csrrw", SYSK_CSRRW, CSR_MSCRATCH, 5'd5, 5'd7, 32'hDEAD_BEEF, 32'h10,
           1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mscratch1", CSR_MSCRATCH, 32'hDEAD_BEEF);

      // 3. set/clear forms
      xact("csrrw_x0", SYSK_CSRRW, CSR_MSCRATCH, 5'd0, 5'd7, 32'h0000_F0F0, 32'h14,
           1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 0);
      xact("csrrsi", SYSK_CSRRSI, CSR_MSCRATCH, 5'd3, 5'h0F, 32'hFFFF_0000, 32'h18,
           1'b1, 32'h0000_F0F0, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mscratch2", CSR_MSCRATCH, 32'h0000_F0FF);
      xact("csrrc", SYSK_CSRRC, CSR_MSCRATCH, 5'd3, 5'd7, 32'h0000_00FF, 32'h1C,
           1'b1, 32'h0000_F0FF, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mscratch3", CSR_MSCRATCH, 32'h0000_F000);
      xact("csrrs_x0", SYSK_CSRRS, CSR_MSCRATCH, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'h20,
           1'b1, 32'h0000_F000, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mscratch4", CSR_MSCRATCH, 32'h0000_F000);

      // 4. traps
      xact("ecall", SYSK_ECALL, 12'h000, 5'd4, 5'd0, 32'd0, 32'h80,
           1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b1, 0);
      rd_csr("mepc_ecall", CSR_MEPC, 32'h80);
      rd_csr("mcause_ecall", CSR_MCAUSE, 32'd11);
      xact("ebreak", SYSK_EBREAK, 12'h000, 5'd4, 5'd0, 32'd0, 32'h84,
           1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b1, 0);
      rd_csr("mcause_ebreak", CSR_MCAUSE, 32'd3);
      xact("bad_addr", SYSK_CSRRW, 12'h7FF, 5'd2, 5'd1, 32'h1234, 32'h88,
           1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b1, 0);
      rd_csr("mcause_bad", CSR_MCAUSE, 32'd2);
      rd_csr("mepc_bad", CSR_MEPC, 32'h88);
      xact("mtvec_wr", SYSK_CSRRW, CSR_MTVEC, 5'd0, 5'd1, 32'h0000_0203, 32'h8C,
           1'b0, 32'h0000_0100, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mtvec1", CSR_MTVEC, 32'h0000_0200);
      xact("invalid", SYSK_INVALID, CSR_MSCRATCH, 5'd2, 5'd1, 32'h5A5A, 32'h90,
           1'b0, 32'd0, 1'b1, 32'h0000_0200, 1'b1, 0);
      rd_csr("mcause_inv", CSR_MCAUSE, 32'd2);
      rd_csr("mscratch_inv", CSR_MSCRATCH, 32'h0000_F000);
      xact("mepc_wr", SYSK_CSRRW, CSR_MEPC, 5'd0, 5'd1, 32'h0000_0087, 32'h94,
           1'b0, 32'h90, 1'b0, 32'd0, 1'b1, 0);
      rd_csr("mepc_mask", CSR_MEPC, 32'h84);

      // 5. back-pressure
      xact("hold", SYSK_CSRRS, CSR_MSCRATCH, 5'd6, 5'd0, 32'd0, 32'h98,
           1'b1, 32'h0000_F000, 1'b0, 32'd0, 1'b1, 5);
      rd_csr("after_hold", CSR_MTVEC, 32'h0000_0200);

      // 6. mcycle carry and reset abort
      rd_csr("mcycleh0", CSR_MCYCLEH, 32'd0);
      xact("mcycle_wr", SYSK_CSRRW, CSR_MCYCLE, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'h9C,
           1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 0);
      rd_csr("mcycleh1", CSR_MCYCLEH, 32'd1);

      req_valid = 1'b1; kind = SYSK_CSRRW; csr_addr = CSR_MSCRATCH; rd = 5'd5;
      rs1 = 5'd1; rs1_val = 32'h5555_5555; pc = 32'hA0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort.no_resp", {30'd0, req_ready, resp_valid}, 32'd2);
      end
      rd_csr("abort.mscratch", CSR_MSCRATCH, 32'd0);
      xact("mcycle_rst", SYSK_CSRRS, CSR_MCYCLE, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0,
           32'd0, 1'b0, 0);
      check("mcycle_rst.small", {31'd0, last_data < 32'd32}, 32'd1);
      check("scoreboard.empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
